// File: rtl/tlb_pipe.sv
// Dual-port LoongArch TLB with registered search, INVTLB masking and a free-running TLBFILL index.
// Optional feature: define TLB_MULTIHIT_EN to register a per-port multi-hit flag.
module tlb_pipe #(
    parameter int  TLBNUM = 16,
    localparam int IDXW   = $clog2(TLBNUM)
) (
    input  logic            clk,
    input  logic            reset,
    // search port 0 (fetch)
    input  logic            s0_req,
    input  logic [18:0]     s0_vppn,
    input  logic            s0_va_bit12,
    input  logic [9:0]      s0_asid,
    output logic            s0_resp,
    output logic            s0_found,
    output logic [IDXW-1:0] s0_index,
    output logic [19:0]     s0_ppn,
    output logic [5:0]      s0_ps,
    output logic [1:0]      s0_plv,
    output logic [1:0]      s0_mat,
    output logic            s0_d,
    output logic            s0_v,
    output logic            s0_multihit,
    // search port 1 (load/store)
    input  logic            s1_req,
    input  logic [18:0]     s1_vppn,
    input  logic            s1_va_bit12,
    input  logic [9:0]      s1_asid,
    output logic            s1_resp,
    output logic            s1_found,
    output logic [IDXW-1:0] s1_index,
    output logic [19:0]     s1_ppn,
    output logic [5:0]      s1_ps,
    output logic [1:0]      s1_plv,
    output logic [1:0]      s1_mat,
    output logic            s1_d,
    output logic            s1_v,
    output logic            s1_multihit,
    // INVTLB
    input  logic            invtlb_valid,
    input  logic [4:0]      invtlb_op,
    input  logic [9:0]      inv_asid,
    input  logic [18:0]     inv_vppn,
    output logic            invtlb_done,
    // write port
    input  logic            we,
    input  logic [IDXW-1:0] w_index,
    input  logic            w_e,
    input  logic [18:0]     w_vppn,
    input  logic [5:0]      w_ps,
    input  logic [9:0]      w_asid,
    input  logic            w_g,
    input  logic [19:0]     w_ppn0,
    input  logic [1:0]      w_plv0,
    input  logic [1:0]      w_mat0,
    input  logic            w_d0,
    input  logic            w_v0,
    input  logic [19:0]     w_ppn1,
    input  logic [1:0]      w_plv1,
    input  logic [1:0]      w_mat1,
    input  logic            w_d1,
    input  logic            w_v1,
    // read port
    input  logic [IDXW-1:0] r_index,
    output logic            r_e,
    output logic [18:0]     r_vppn,
    output logic [5:0]      r_ps,
    output logic [9:0]      r_asid,
    output logic            r_g,
    output logic [19:0]     r_ppn0,
    output logic [1:0]      r_plv0,
    output logic [1:0]      r_mat0,
    output logic            r_d0,
    output logic            r_v0,
    output logic [19:0]     r_ppn1,
    output logic [1:0]      r_plv1,
    output logic [1:0]      r_mat1,
    output logic            r_d1,
    output logic            r_v1,
    // TLBFILL victim
    output logic [IDXW-1:0] fill_index
);

    logic [TLBNUM-1:0] tlb_e;
    logic [TLBNUM-1:0] tlb_g;
    logic [TLBNUM-1:0] tlb_ps4mb;
    logic [TLBNUM-1:0] tlb_d0;
    logic [TLBNUM-1:0] tlb_d1;
    logic [TLBNUM-1:0] tlb_v0;
    logic [TLBNUM-1:0] tlb_v1;
    logic [18:0]       tlb_vppn [TLBNUM];
    logic [9:0]        tlb_asid [TLBNUM];
    logic [19:0]       tlb_ppn0 [TLBNUM];
    logic [19:0]       tlb_ppn1 [TLBNUM];
    logic [1:0]        tlb_plv0 [TLBNUM];
    logic [1:0]        tlb_plv1 [TLBNUM];
    logic [1:0]        tlb_mat0 [TLBNUM];
    logic [1:0]        tlb_mat1 [TLBNUM];

    // Entry payload is deliberately unreset; only tlb_e needs a defined value.
    always_ff @(posedge clk) begin
        if (we) begin
            tlb_vppn[w_index]  <= w_vppn;
            tlb_asid[w_index]  <= w_asid;
            tlb_g[w_index]     <= w_g;
            tlb_ps4mb[w_index] <= (w_ps == 6'd21);
            tlb_ppn0[w_index]  <= w_ppn0;
            tlb_plv0[w_index]  <= w_plv0;
            tlb_mat0[w_index]  <= w_mat0;
            tlb_d0[w_index]    <= w_d0;
            tlb_v0[w_index]    <= w_v0;
            tlb_ppn1[w_index]  <= w_ppn1;
            tlb_plv1[w_index]  <= w_plv1;
            tlb_mat1[w_index]  <= w_mat1;
            tlb_d1[w_index]    <= w_d1;
            tlb_v1[w_index]    <= w_v1;
        end
    end

    logic [TLBNUM-1:0] inv_asid_hit;
    logic [TLBNUM-1:0] inv_vppn_hit;
    logic [TLBNUM-1:0] inv_mask;
    logic [TLBNUM-1:0] tlb_e_next;

    always_comb begin
        inv_asid_hit = '0;
        inv_vppn_hit = '0;
        for (int i = 0; i < TLBNUM; i++) begin
            inv_asid_hit[i] = (tlb_asid[i] == inv_asid);
            inv_vppn_hit[i] = (tlb_vppn[i][18:10] == inv_vppn[18:10]) &&
                              (tlb_ps4mb[i] || (tlb_vppn[i][9:0] == inv_vppn[9:0]));
        end
    end

    always_comb begin
        inv_mask = '0;
        case (invtlb_op)
            5'd0, 5'd1: inv_mask = '1;
            5'd2:       inv_mask = tlb_g;
            5'd3:       inv_mask = ~tlb_g;
            5'd4:       inv_mask = ~tlb_g & inv_asid_hit;
            5'd5:       inv_mask = ~tlb_g & inv_asid_hit & inv_vppn_hit;
            5'd6:       inv_mask = (tlb_g | inv_asid_hit) & inv_vppn_hit;
            default:    inv_mask = '0;
        endcase
    end

    // A write to the same entry as an INVTLB overrides the invalidation.
    always_comb begin
        tlb_e_next = tlb_e;
        if (invtlb_valid) begin
            tlb_e_next = tlb_e & ~inv_mask;
        end
        if (we) begin
            tlb_e_next[w_index] = w_e;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tlb_e       <= '0;
            invtlb_done <= 1'b0;
        end else begin
            tlb_e       <= tlb_e_next;
            invtlb_done <= invtlb_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fill_index <= '0;
        end else if (fill_index == IDXW'(TLBNUM - 1)) begin
            fill_index <= '0;
        end else begin
            fill_index <= fill_index + 1'b1;
        end
    end

    logic        sreq   [2];
    logic [18:0] svppn  [2];
    logic        sbit12 [2];
    logic [9:0]  sasid  [2];

    assign sreq[0]   = s0_req;
    assign svppn[0]  = s0_vppn;
    assign sbit12[0] = s0_va_bit12;
    assign sasid[0]  = s0_asid;
    assign sreq[1]   = s1_req;
    assign svppn[1]  = s1_vppn;
    assign sbit12[1] = s1_va_bit12;
    assign sasid[1]  = s1_asid;

    logic [TLBNUM-1:0] smatch [2];

    always_comb begin
        for (int p = 0; p < 2; p++) begin
            smatch[p] = '0;
            for (int i = 0; i < TLBNUM; i++) begin
                smatch[p][i] = tlb_e[i] &&
                               ((sasid[p] == tlb_asid[i]) || tlb_g[i]) &&
                               (svppn[p][18:10] == tlb_vppn[i][18:10]) &&
                               (tlb_ps4mb[i] || (svppn[p][9:0] == tlb_vppn[i][9:0]));
            end
        end
    end

    logic            shit      [2];
    logic [IDXW-1:0] sidx      [2];
    logic            sodd      [2];
    logic            sel_ps4mb [2];
    logic [19:0]     sel_ppn   [2];
    logic [1:0]      sel_plv   [2];
    logic [1:0]      sel_mat   [2];
    logic            sel_d     [2];
    logic            sel_v     [2];

    // Scanning downward leaves the lowest matching index as the winner.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            shit[p] = |smatch[p];
            sidx[p] = '0;
            for (int i = TLBNUM - 1; i >= 0; i--) begin
                if (smatch[p][i]) begin
                    sidx[p] = IDXW'(i);
                end
            end
            sel_ps4mb[p] = tlb_ps4mb[sidx[p]];
            sodd[p]      = sel_ps4mb[p] ? svppn[p][8] : sbit12[p];
            sel_ppn[p]   = sodd[p] ? tlb_ppn1[sidx[p]] : tlb_ppn0[sidx[p]];
            sel_plv[p]   = sodd[p] ? tlb_plv1[sidx[p]] : tlb_plv0[sidx[p]];
            sel_mat[p]   = sodd[p] ? tlb_mat1[sidx[p]] : tlb_mat0[sidx[p]];
            sel_d[p]     = sodd[p] ? tlb_d1[sidx[p]]   : tlb_d0[sidx[p]];
            sel_v[p]     = sodd[p] ? tlb_v1[sidx[p]]   : tlb_v0[sidx[p]];
        end
    end

    logic            sresp_q  [2];
    logic            sfound_q [2];
    logic [IDXW-1:0] sidx_q   [2];
    logic [19:0]     sppn_q   [2];
    logic [5:0]      sps_q    [2];
    logic [1:0]      splv_q   [2];
    logic [1:0]      smat_q   [2];
    logic            sd_q     [2];
    logic            sv_q     [2];

    // Result registers only update on a request; a miss clears every field.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                sresp_q[p]  <= 1'b0;
                sfound_q[p] <= 1'b0;
                sidx_q[p]   <= '0;
                sppn_q[p]   <= '0;
                sps_q[p]    <= '0;
                splv_q[p]   <= '0;
                smat_q[p]   <= '0;
                sd_q[p]     <= 1'b0;
                sv_q[p]     <= 1'b0;
            end else begin
                sresp_q[p] <= sreq[p];
                if (sreq[p]) begin
                    sfound_q[p] <= shit[p];
                    sidx_q[p]   <= shit[p] ? sidx[p] : '0;
                    sppn_q[p]   <= shit[p] ? sel_ppn[p] : '0;
                    sps_q[p]    <= !shit[p] ? 6'd0 : (sel_ps4mb[p] ? 6'd21 : 6'd12);
                    splv_q[p]   <= shit[p] ? sel_plv[p] : '0;
                    smat_q[p]   <= shit[p] ? sel_mat[p] : '0;
                    sd_q[p]     <= shit[p] && sel_d[p];
                    sv_q[p]     <= shit[p] && sel_v[p];
                end
            end
        end
    end

`ifdef TLB_MULTIHIT_EN
    logic smulti_q [2];

    // Clearing the lowest set bit leaves something only when two or more matched.
    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (reset) begin
                smulti_q[p] <= 1'b0;
            end else if (sreq[p]) begin
                smulti_q[p] <= (smatch[p] & (smatch[p] - TLBNUM'(1))) != '0;
            end
        end
    end

    assign s0_multihit = smulti_q[0];
    assign s1_multihit = smulti_q[1];
`else
    assign s0_multihit = 1'b0;
    assign s1_multihit = 1'b0;
`endif

    assign s0_resp  = sresp_q[0];
    assign s0_found = sfound_q[0];
    assign s0_index = sidx_q[0];
    assign s0_ppn   = sppn_q[0];
    assign s0_ps    = sps_q[0];
    assign s0_plv   = splv_q[0];
    assign s0_mat   = smat_q[0];
    assign s0_d     = sd_q[0];
    assign s0_v     = sv_q[0];
    assign s1_resp  = sresp_q[1];
    assign s1_found = sfound_q[1];
    assign s1_index = sidx_q[1];
    assign s1_ppn   = sppn_q[1];
    assign s1_ps    = sps_q[1];
    assign s1_plv   = splv_q[1];
    assign s1_mat   = smat_q[1];
    assign s1_d     = sd_q[1];
    assign s1_v     = sv_q[1];

    assign r_e    = tlb_e[r_index];
    assign r_vppn = tlb_vppn[r_index];
    assign r_ps   = tlb_ps4mb[r_index] ? 6'd21 : 6'd12;
    assign r_asid = tlb_asid[r_index];
    assign r_g    = tlb_g[r_index];
    assign r_ppn0 = tlb_ppn0[r_index];
    assign r_plv0 = tlb_plv0[r_index];
    assign r_mat0 = tlb_mat0[r_index];
    assign r_d0   = tlb_d0[r_index];
    assign r_v0   = tlb_v0[r_index];
    assign r_ppn1 = tlb_ppn1[r_index];
    assign r_plv1 = tlb_plv1[r_index];
    assign r_mat1 = tlb_mat1[r_index];
    assign r_d1   = tlb_d1[r_index];
    assign r_v1   = tlb_v1[r_index];

endmodule

// File: tb/tb_tlb_pipe.sv
// Self-checking bench for tlb_pipe: table-driven searches with a response scoreboard plus
// hand-written INVTLB, same-cycle, multi-hit, reset and fill-index sequences.
module tb_tlb_pipe;

    localparam int TLBNUM = 16;
    localparam int IDXW   = 4;
`ifdef TLB_MULTIHIT_EN
    localparam logic MH_EXP = 1'b1;
`else
    localparam logic MH_EXP = 1'b0;
`endif

    typedef struct packed {
        logic            found;
        logic [IDXW-1:0] index;
        logic [19:0]     ppn;
        logic [5:0]      ps;
        logic [1:0]      plv;
        logic [1:0]      mat;
        logic            d;
        logic            v;
        logic            mh;
    } res_t;

    typedef struct packed {
        logic [18:0] vppn;
        logic [5:0]  ps;
        logic [9:0]  asid;
        logic        g;
        logic [19:0] ppn0;
        logic [1:0]  plv0;
        logic [1:0]  mat0;
        logic        d0;
        logic        v0;
        logic [19:0] ppn1;
        logic [1:0]  plv1;
        logic [1:0]  mat1;
        logic        d1;
        logic        v1;
    } wr_t;

    typedef struct {
        logic [18:0] vppn;
        logic        bit12;
        logic [9:0]  asid;
        res_t        exp;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    logic s0_req, s0_va_bit12, s1_req, s1_va_bit12;
    logic [18:0] s0_vppn, s1_vppn;
    logic [9:0] s0_asid, s1_asid;
    logic s0_resp, s0_found, s0_d, s0_v, s0_multihit;
    logic s1_resp, s1_found, s1_d, s1_v, s1_multihit;
    logic [IDXW-1:0] s0_index, s1_index;
    logic [19:0] s0_ppn, s1_ppn;
    logic [5:0] s0_ps, s1_ps;
    logic [1:0] s0_plv, s0_mat, s1_plv, s1_mat;
    logic invtlb_valid, invtlb_done;
    logic [4:0] invtlb_op;
    logic [9:0] inv_asid;
    logic [18:0] inv_vppn;
    logic we, w_e, w_g, w_d0, w_v0, w_d1, w_v1;
    logic [IDXW-1:0] w_index, r_index, fill_index;
    logic [18:0] w_vppn, r_vppn;
    logic [5:0] w_ps, r_ps;
    logic [9:0] w_asid, r_asid;
    logic [19:0] w_ppn0, w_ppn1, r_ppn0, r_ppn1;
    logic [1:0] w_plv0, w_mat0, w_plv1, w_mat1, r_plv0, r_mat0, r_plv1, r_mat1;
    logic r_e, r_g, r_d0, r_v0, r_d1, r_v1;

    int checks = 0;
    int failures = 0;
    res_t q0[$];
    res_t q1[$];
    vec_t vecs[7];

    tlb_pipe #(.TLBNUM(TLBNUM)) dut (
        .clk(clk), .reset(reset),
        .s0_req(s0_req), .s0_vppn(s0_vppn), .s0_va_bit12(s0_va_bit12), .s0_asid(s0_asid),
        .s0_resp(s0_resp), .s0_found(s0_found), .s0_index(s0_index), .s0_ppn(s0_ppn),
        .s0_ps(s0_ps), .s0_plv(s0_plv), .s0_mat(s0_mat), .s0_d(s0_d), .s0_v(s0_v),
        .s0_multihit(s0_multihit),
        .s1_req(s1_req), .s1_vppn(s1_vppn), .s1_va_bit12(s1_va_bit12), .s1_asid(s1_asid),
        .s1_resp(s1_resp), .s1_found(s1_found), .s1_index(s1_index), .s1_ppn(s1_ppn),
        .s1_ps(s1_ps), .s1_plv(s1_plv), .s1_mat(s1_mat), .s1_d(s1_d), .s1_v(s1_v),
        .s1_multihit(s1_multihit),
        .invtlb_valid(invtlb_valid), .invtlb_op(invtlb_op), .inv_asid(inv_asid),
        .inv_vppn(inv_vppn), .invtlb_done(invtlb_done),
        .we(we), .w_index(w_index), .w_e(w_e), .w_vppn(w_vppn), .w_ps(w_ps),
        .w_asid(w_asid), .w_g(w_g),
        .w_ppn0(w_ppn0), .w_plv0(w_plv0), .w_mat0(w_mat0), .w_d0(w_d0), .w_v0(w_v0),
        .w_ppn1(w_ppn1), .w_plv1(w_plv1), .w_mat1(w_mat1), .w_d1(w_d1), .w_v1(w_v1),
        .r_index(r_index), .r_e(r_e), .r_vppn(r_vppn), .r_ps(r_ps), .r_asid(r_asid),
        .r_g(r_g),
        .r_ppn0(r_ppn0), .r_plv0(r_plv0), .r_mat0(r_mat0), .r_d0(r_d0), .r_v0(r_v0),
        .r_ppn1(r_ppn1), .r_plv1(r_plv1), .r_mat1(r_mat1), .r_d1(r_d1), .r_v1(r_v1),
        .fill_index(fill_index)
    );

    always #5 clk = ~clk;

    function automatic res_t mk(input logic f, input int idx, input logic [19:0] ppn,
                                input int ps, input int plv, input int mat,
                                input logic d, input logic v, input logic mh);
        res_t r;
        r.found = f;
        r.index = IDXW'(idx);
        r.ppn   = ppn;
        r.ps    = 6'(ps);
        r.plv   = 2'(plv);
        r.mat   = 2'(mat);
        r.d     = d;
        r.v     = v;
        r.mh    = mh;
        return r;
    endfunction

    function automatic wr_t mkw(input logic [18:0] vppn, input int ps, input int asid,
                                input logic g, input logic [19:0] ppn0, input int plv0,
                                input int mat0, input logic d0, input logic v0,
                                input logic [19:0] ppn1, input int plv1, input int mat1,
                                input logic d1, input logic v1);
        wr_t w;
        w.vppn = vppn;  w.ps = 6'(ps);  w.asid = 10'(asid);  w.g = g;
        w.ppn0 = ppn0;  w.plv0 = 2'(plv0);  w.mat0 = 2'(mat0);  w.d0 = d0;  w.v0 = v0;
        w.ppn1 = ppn1;  w.plv1 = 2'(plv1);  w.mat1 = 2'(mat1);  w.d1 = d1;  w.v1 = v1;
        return w;
    endfunction

    function automatic res_t act0();
        return {s0_found, s0_index, s0_ppn, s0_ps, s0_plv, s0_mat, s0_d, s0_v, s0_multihit};
    endfunction

    function automatic res_t act1();
        return {s1_found, s1_index, s1_ppn, s1_ps, s1_plv, s1_mat, s1_d, s1_v, s1_multihit};
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_output(input string name, input logic exp_resp, input logic resp,
                                input logic has_exp, input res_t exp, input res_t act);
        check_val({name, "_resp"}, 64'(resp), 64'(exp_resp));
        if (exp_resp) begin
            checks++;
            if (!has_exp) begin
                failures++;
                $display("[TB] FAIL %s_sb: response with empty scoreboard, got 0x%0h", name, act);
            end else if (act !== exp) begin
                failures++;
                $display("[TB] FAIL %s_result: got 0x%0h expected 0x%0h", name, act, exp);
            end
        end
    endtask

    // One clock: expectations are derived from the inputs in effect at the edge.
    task automatic apply_stimulus();
        logic e0, e1, ed, h0, h1;
        res_t x0, x1;
        e0 = s0_req && !reset;
        e1 = s1_req && !reset;
        ed = invtlb_valid && !reset;
        h0 = 1'b0;
        h1 = 1'b0;
        x0 = '0;
        x1 = '0;
        if (reset) begin
            q0.delete();
            q1.delete();
        end
        if (e0 && q0.size() > 0) begin x0 = q0.pop_front(); h0 = 1'b1; end
        if (e1 && q1.size() > 0) begin x1 = q1.pop_front(); h1 = 1'b1; end
        @(posedge clk);
        #1;
        s0_req = 1'b0;
        s1_req = 1'b0;
        we = 1'b0;
        invtlb_valid = 1'b0;
        check_output("s0", e0, s0_resp, h0, x0, act0());
        check_output("s1", e1, s1_resp, h1, x1, act1());
        check_val("invtlb_done", 64'(invtlb_done), 64'(ed));
    endtask

    task automatic search(input int port, input logic [18:0] vppn, input logic b12,
                          input logic [9:0] asid, input res_t exp);
        if (port == 0) begin
            s0_req = 1'b1; s0_vppn = vppn; s0_va_bit12 = b12; s0_asid = asid;
            q0.push_back(exp);
        end else begin
            s1_req = 1'b1; s1_vppn = vppn; s1_va_bit12 = b12; s1_asid = asid;
            q1.push_back(exp);
        end
    endtask

    task automatic set_write(input int idx, input logic e, input wr_t w);
        we = 1'b1;  w_index = IDXW'(idx);  w_e = e;
        w_vppn = w.vppn;  w_ps = w.ps;  w_asid = w.asid;  w_g = w.g;
        w_ppn0 = w.ppn0;  w_plv0 = w.plv0;  w_mat0 = w.mat0;  w_d0 = w.d0;  w_v0 = w.v0;
        w_ppn1 = w.ppn1;  w_plv1 = w.plv1;  w_mat1 = w.mat1;  w_d1 = w.d1;  w_v1 = w.v1;
    endtask

    task automatic set_inv(input int op, input int asid, input logic [18:0] vppn);
        invtlb_valid = 1'b1;
        invtlb_op = 5'(op);
        inv_asid = 10'(asid);
        inv_vppn = vppn;
    endtask

    task automatic check_e(input string name, input int idx, input logic exp);
        r_index = IDXW'(idx);
        #1;
        check_val(name, 64'(r_e), 64'(exp));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        apply_stimulus();
        apply_stimulus();
        reset = 1'b0;
    endtask

    initial begin
        wr_t e3, e7, ge, ne;
        reset = 1'b1;
        s0_req = 0; s0_vppn = 0; s0_va_bit12 = 0; s0_asid = 0;
        s1_req = 0; s1_vppn = 0; s1_va_bit12 = 0; s1_asid = 0;
        invtlb_valid = 0; invtlb_op = 0; inv_asid = 0; inv_vppn = 0;
        we = 0; w_index = 0; w_e = 0; w_vppn = 0; w_ps = 0; w_asid = 0; w_g = 0;
        w_ppn0 = 0; w_plv0 = 0; w_mat0 = 0; w_d0 = 0; w_v0 = 0;
        w_ppn1 = 0; w_plv1 = 0; w_mat1 = 0; w_d1 = 0; w_v1 = 0;
        r_index = 0;

        e3 = mkw(19'h12345, 12, 5, 1'b0, 20'hAAAAA, 1, 1, 1'b1, 1'b1, 20'hBBBBB, 2, 2, 1'b0, 1'b1);
        e7 = mkw(19'h40000, 21, 3, 1'b1, 20'h11111, 0, 0, 1'b0, 1'b1, 20'h22222, 3, 1, 1'b1, 1'b1);
        vecs[0] = '{19'h12345, 1'b1, 10'd5, mk(1, 3, 20'hBBBBB, 12, 2, 2, 0, 1, 0)};
        vecs[1] = '{19'h12345, 1'b0, 10'd5, mk(1, 3, 20'hAAAAA, 12, 1, 1, 1, 1, 0)};
        vecs[2] = '{19'h12345, 1'b1, 10'd6, mk(0, 0, 20'h0, 0, 0, 0, 0, 0, 0)};
        vecs[3] = '{19'h401FF, 1'b0, 10'd9, mk(1, 7, 20'h22222, 21, 3, 1, 1, 1, 0)};
        vecs[4] = '{19'h400FF, 1'b1, 10'd9, mk(1, 7, 20'h11111, 21, 0, 0, 0, 1, 0)};
        vecs[5] = '{19'h40400, 1'b0, 10'd3, mk(0, 0, 20'h0, 0, 0, 0, 0, 0, 0)};
        vecs[6] = '{19'h12344, 1'b1, 10'd5, mk(0, 0, 20'h0, 0, 0, 0, 0, 0, 0)};

        // Reset state and fill counter sequence
        do_reset();
        check_val("reset_s0", 64'(act0()), 64'(0));
        check_val("reset_s1", 64'(act1()), 64'(0));
        for (int k = 0; k <= TLBNUM; k++) begin
            check_val($sformatf("fill_index_%0d", k), 64'(fill_index), 64'(k % TLBNUM));
            apply_stimulus();
        end

        // Search on an empty TLB
        search(0, 19'h12345, 1'b1, 10'd5, mk(0, 0, 20'h0, 0, 0, 0, 0, 0, 0));
        apply_stimulus();

        set_write(3, 1'b1, e3);
        apply_stimulus();
        set_write(7, 1'b1, e7);
        apply_stimulus();
        r_index = 4'd3;
        #1;
        check_val("read3", {r_e, r_vppn, r_ps, r_g, r_ppn1}, {1'b1, 19'h12345, 6'd12, 1'b0, 20'hBBBBB});
        r_index = 4'd7;
        #1;
        check_val("read7", {r_e, r_vppn, r_ps, r_g, r_ppn0}, {1'b1, 19'h40000, 6'd21, 1'b1, 20'h11111});

        // Back-to-back table searches on both ports
        for (int i = 0; i < 7; i++) begin
            search(0, vecs[i].vppn, vecs[i].bit12, vecs[i].asid, vecs[i].exp);
            search(1, vecs[(i + 3) % 7].vppn, vecs[(i + 3) % 7].bit12,
                   vecs[(i + 3) % 7].asid, vecs[(i + 3) % 7].exp);
            apply_stimulus();
        end

        // Results hold without a request
        search(0, vecs[0].vppn, vecs[0].bit12, vecs[0].asid, vecs[0].exp);
        apply_stimulus();
        apply_stimulus();
        check_val("hold_s0", 64'(act0()), 64'(vecs[0].exp));

        // INVTLB op masks
        do_reset();
        ge = mkw(19'h00001, 12, 0, 1'b1, 20'h1, 0, 0, 0, 1, 20'h1, 0, 0, 0, 1);
        ne = mkw(19'h00002, 12, 4, 1'b0, 20'h2, 0, 0, 0, 1, 20'h2, 0, 0, 0, 1);
        set_write(1, 1'b1, ge);  apply_stimulus();
        set_write(2, 1'b1, ne);  apply_stimulus();
        set_inv(3, 0, 19'h0);    apply_stimulus();
        check_e("op3_e1", 1, 1'b1);
        check_e("op3_e2", 2, 1'b0);
        set_inv(2, 0, 19'h0);    apply_stimulus();
        check_e("op2_e1", 1, 1'b0);
        set_write(1, 1'b1, ge);  apply_stimulus();
        set_write(2, 1'b1, ne);  apply_stimulus();
        set_write(4, 1'b1, mkw(19'h00004, 12, 6, 1'b0, 20'h4, 0, 0, 0, 1, 20'h4, 0, 0, 0, 1));
        apply_stimulus();
        set_inv(9, 4, 19'h00002); apply_stimulus();
        check_e("op9_e1", 1, 1'b1);
        check_e("op9_e2", 2, 1'b1);
        set_inv(5, 4, 19'h00003); apply_stimulus();
        check_e("op5_nomatch_e2", 2, 1'b1);
        set_inv(4, 4, 19'h0);     apply_stimulus();
        check_e("op4_e2", 2, 1'b0);
        check_e("op4_e4", 4, 1'b1);
        set_inv(6, 6, 19'h00004); apply_stimulus();
        check_e("op6_e4", 4, 1'b0);
        check_e("op6_e1", 1, 1'b1);

        // Same-cycle write, INVTLB op0 and search
        do_reset();
        set_write(6, 1'b1, mkw(19'h00666, 12, 1, 1'b0, 20'h6, 0, 0, 0, 1, 20'h6, 0, 0, 0, 1));
        apply_stimulus();
        set_write(5, 1'b1, mkw(19'h00555, 12, 1, 1'b0, 20'h55555, 0, 1, 1, 1, 20'h5, 0, 0, 0, 1));
        set_inv(0, 0, 19'h0);
        search(1, 19'h00555, 1'b0, 10'd1, mk(0, 0, 20'h0, 0, 0, 0, 0, 0, 0));
        apply_stimulus();
        check_e("same_cycle_e5", 5, 1'b1);
        check_e("same_cycle_e6", 6, 1'b0);
        search(1, 19'h00555, 1'b0, 10'd1, mk(1, 5, 20'h55555, 12, 0, 1, 1, 1, 0));
        apply_stimulus();

        // Two matching entries: lowest index wins
        set_write(10, 1'b1, mkw(19'h07777, 12, 2, 1'b0, 20'h0A0A0, 0, 0, 0, 1, 20'h0, 0, 0, 0, 1));
        apply_stimulus();
        set_write(8, 1'b1, mkw(19'h07777, 12, 2, 1'b0, 20'h08888, 1, 0, 0, 1, 20'h0, 0, 0, 0, 1));
        apply_stimulus();
        search(0, 19'h07777, 1'b0, 10'd2, mk(1, 8, 20'h08888, 12, 1, 0, 0, 1, MH_EXP));
        apply_stimulus();

        // Reset arriving with a request drops the response
        search(0, 19'h07777, 1'b0, 10'd2, mk(1, 8, 20'h08888, 12, 1, 0, 0, 1, MH_EXP));
        reset = 1'b1;
        apply_stimulus();
        reset = 1'b0;
        apply_stimulus();
        check_val("reset_drop_found", 64'(s0_found), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
